// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests into the stall bus, sequences
// exception/ERET flushes (deferred while MEM is busy), and tracks stall debug counters.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_is_eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_RECOV = 2'd2;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              lat_eret;
    logic [31:0]       lat_epc;
    logic              lat_en;
    logic [WDOG_W-1:0] wdog_cnt;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              id_req;

    // State register and event latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            lat_eret <= 1'b0;
            lat_epc  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (lat_en) begin
                lat_eret <= exc_is_eret;
                lat_epc  <= cp0_epc;
            end
        end
    end

    // Next state, stall bus and flush/redirect decode
    always_comb begin
        state_nxt = state;
        stall     = STALL_NONE;
        flush     = 1'b0;
        new_pc    = 32'h0;
        lat_en    = 1'b0;
        // ID holds a squashed slot in the cycle right after a flush
        id_req    = stallreq_id && (state != ST_RECOV);

        if (!rst) begin
            if (state == ST_PEND) begin
                if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else begin
                    flush     = 1'b1;
                    new_pc    = lat_eret ? lat_epc : EXC_VECTOR;
                    state_nxt = ST_RECOV;
                end
            end else if (exc_valid) begin
                if (stallreq_mem) begin
                    stall     = STALL_MEM;
                    lat_en    = 1'b1;
                    state_nxt = ST_PEND;
                end else begin
                    flush     = 1'b1;
                    new_pc    = exc_is_eret ? cp0_epc : EXC_VECTOR;
                    state_nxt = ST_RECOV;
                end
            end else begin
                state_nxt = ST_RUN;
                if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall = STALL_EX;
                end else if (id_req) begin
                    stall = STALL_ID;
                end
            end
        end
    end

    // Saturating consecutive-stall count for the watchdog
    always_comb begin
        wdog_nxt = WDOG_W'(0);
        if (stall[0]) begin
            wdog_nxt = (wdog_cnt == WDOG_MAX) ? wdog_cnt : wdog_cnt + WDOG_W'(1);
        end
    end

    // Debug counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= 32'h0;
            wdog_cnt      <= WDOG_W'(0);
            stall_timeout <= 1'b0;
        end else begin
            if (stall[0]) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            wdog_cnt      <= wdog_nxt;
            stall_timeout <= stall_timeout || (wdog_nxt == WDOG_MAX);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, flush/defer sequencing,
// RECOV masking, watchdog and reset behaviour.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_valid;
    logic        exc_is_eret;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    int n_vec = 0;
    int n_err = 0;

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDOG_LIMIT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .exc_valid     (exc_valid),
        .exc_is_eret   (exc_is_eret),
        .cp0_epc       (cp0_epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Apply inputs just after a rising edge, let combinational outputs settle
    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic exc, input logic eret, input logic [31:0] epc);
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        exc_valid    = exc;
        exc_is_eret  = eret;
        cp0_epc      = epc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_comb(input string tag, input logic [5:0] s, input logic f, input logic [31:0] pc);
        check({tag, ".stall"}, 32'(stall), 32'(s));
        check({tag, ".flush"}, 32'(flush), 32'(f));
        check({tag, ".new_pc"}, new_pc, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234);
        check_comb("in_rst", 6'h00, 1'b0, 32'h0);
        tick();
        tick();
        check("rst.stall_cycles", stall_cycles, 32'd0);
        check("rst.timeout", 32'(stall_timeout), 32'd0);

        // 1: stall priority ID/EX
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t1.c1", 6'h07, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t1.c2", 6'h0F, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t1.c3", 6'h07, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_comb("t1.mem_prio", 6'h1F, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("t1.stall_cycles", stall_cycles, 32'd3);

        // 2: immediate exception flush, ID masked in RECOV
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5555);
        check_comb("t2.flush", 6'h00, 1'b1, 32'h20);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t2.recov_mask", 6'h00, 1'b0, 32'h0);
        tick();
        check_comb("t2.run_id", 6'h07, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("t2.stall_cycles", stall_cycles, 32'd1);

        // 3: ERET deferred behind MEM stall uses latched EPC
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1004);
        check_comb("t3.defer", 6'h1F, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, (i == 1), 1'b0, 32'h0000_BAD0);
            check_comb($sformatf("t3.pend%0d", i), 6'h1F, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_BAD0);
        check_comb("t3.fire", 6'h00, 1'b1, 32'h0000_1004);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t3.recov_ex", 6'h0F, 1'b0, 32'h0);
        check("t3.stall_cycles", stall_cycles, 32'd4);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // 4: watchdog at WDOG_LIMIT=8
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("t4.timeout_c7", 32'(stall_timeout), 32'd0);
        end
        check("t4.timeout_c8", 32'(stall_timeout), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("t4.timeout_sticky", 32'(stall_timeout), 32'd1);
        check("t4.stall_cycles", stall_cycles, 32'd8);

        // 5: reset while pending discards the exception
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_comb("t5.in_rst", 6'h00, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t5.no_fire", 6'h00, 1'b0, 32'h0);
        check("t5.stall_cycles", stall_cycles, 32'd0);
        check("t5.timeout", 32'(stall_timeout), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t5.run", 6'h07, 1'b0, 32'h0);
        tick();

        // 6: second flush taken in RECOV
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_comb("t6.flush1", 6'h00, 1'b1, 32'h20);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
        check_comb("t6.flush2", 6'h00, 1'b1, 32'h0000_2000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_comb("t6.recov_mask", 6'h00, 1'b0, 32'h0);
        tick();
        check_comb("t6.run_id", 6'h07, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
